// File: rtl/rx_slicer_decim.sv
// Symbol-rate decimator and 4-ASK decision slicer with a self-tracking reference level.
// Keeps one filter sample per symbol and outputs the 2-bit decision, its error and the reference.
module rx_slicer_decim #(
    parameter int unsigned SPS      = 4,
    parameter int unsigned AVG_LOG2 = 8,
    parameter int unsigned REF_INIT = 65536
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sam_en,
    input  logic [$clog2(SPS)-1:0]   phase_sel,
    input  logic signed [17:0]       in,
    output logic                     sym_valid,
    output logic [1:0]               sym_out,
    output logic signed [17:0]       err,
    output logic [17:0]              ref_level
);

    localparam int unsigned PW = $clog2(SPS);
    localparam int unsigned AW = 17 + AVG_LOG2;

    logic [PW-1:0]       cnt_q;
    logic                v1_q;
    logic signed [17:0]  x_q;
    logic [AVG_LOG2-1:0] scnt_q;
    logic [AW-1:0]       acc_q;

    logic                accept;
    logic signed [19:0]  xs, rs, half_r, three_half_r, level, err_full;
    logic signed [17:0]  neg_x;
    logic [16:0]         abs_x;
    logic [1:0]          slice_sym;
    logic [AW-1:0]       acc_sum;
    logic                unused_bits;

    assign accept = sam_en && (cnt_q == phase_sel);

    // Ref is an unsigned 18-bit value, so all level arithmetic runs in 20-bit signed.
    assign xs           = {{2{x_q[17]}}, x_q};
    assign rs           = {2'b00, ref_level};
    assign half_r       = {3'b000, ref_level[17:1]};
    assign three_half_r = rs + half_r;

    always_comb begin
        slice_sym = 2'b00;
        level     = -three_half_r;
        if (xs >= rs) begin
            slice_sym = 2'b11;
            level     = three_half_r;
        end else if (!x_q[17]) begin
            slice_sym = 2'b10;
            level     = half_r;
        end else if (xs >= -rs) begin
            slice_sym = 2'b01;
            level     = -half_r;
        end
    end

    // Slice regions bound |err| below 2^17, so dropping the top two bits is exact.
    assign err_full = xs - level;

    assign neg_x = -x_q;
    always_comb begin
        abs_x = x_q[16:0];
        if (x_q == 18'sh20000) begin
            abs_x = 17'h1ffff;
        end else if (x_q[17]) begin
            abs_x = neg_x[16:0];
        end
    end

    assign acc_sum     = acc_q + {{AVG_LOG2{1'b0}}, abs_x};
    assign unused_bits = ^{err_full[19:18], neg_x[17]};

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            v1_q      <= 1'b0;
            x_q       <= '0;
            scnt_q    <= '0;
            acc_q     <= '0;
            sym_valid <= 1'b0;
            sym_out   <= 2'b00;
            err       <= '0;
            ref_level <= REF_INIT[17:0];
        end else begin
            if (sam_en) begin
                cnt_q <= cnt_q + 1'b1;
            end
            v1_q <= accept;
            if (accept) begin
                x_q <= in;
            end
            sym_valid <= v1_q;
            if (v1_q) begin
                sym_out <= slice_sym;
                err     <= err_full[17:0];
                scnt_q  <= scnt_q + 1'b1;
                if (&scnt_q) begin
                    ref_level <= {1'b0, acc_sum[AW-1:AVG_LOG2]};
                    acc_q     <= '0;
                end else begin
                    acc_q <= acc_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_slicer_decim.sv
// Directed bench for rx_slicer_decim (SPS=4, AVG_LOG2=2): slicing table plus
// phase-selection, reference-tracking, extreme-value and mid-flight reset sequences.
module tb_rx_slicer_decim;

    logic               clk = 1'b0;
    logic               reset;
    logic               sam_en;
    logic [1:0]         phase_sel;
    logic signed [17:0] in_s;
    logic               sym_valid;
    logic [1:0]         sym_out;
    logic signed [17:0] err;
    logic [17:0]        ref_level;

    int checks = 0;
    int errors = 0;
    int tb_cnt = 0;

    typedef struct {
        string name;
        int    x;
        int    sym;
        int    err;
    } vec_t;

    vec_t vecs[5];

    rx_slicer_decim #(
        .SPS      (4),
        .AVG_LOG2 (2),
        .REF_INIT (65536)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sam_en    (sam_en),
        .phase_sel (phase_sel),
        .in        (in_s),
        .sym_valid (sym_valid),
        .sym_out   (sym_out),
        .err       (err),
        .ref_level (ref_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        reset  = 1'b1;
        sam_en = 1'b0;
        repeat (n) @(negedge clk);
        reset  = 1'b0;
        tb_cnt = 0;
    endtask

    // Present one sample at the current phase count; returns at the negedge after acceptance.
    task automatic send(input int x);
        phase_sel = tb_cnt[1:0];
        in_s      = x[17:0];
        sam_en    = 1'b1;
        @(negedge clk);
        sam_en = 1'b0;
        tb_cnt = (tb_cnt + 1) % 4;
    endtask

    task automatic slice(input string name, input int x, input int sym, input int e);
        send(x);
        chk({name, " valid_early"}, int'(sym_valid), 0);
        @(negedge clk);
        chk({name, " valid"}, int'(sym_valid), 1);
        chk({name, " sym"}, int'(sym_out), sym);
        chk({name, " err"}, int'(err), e);
        @(negedge clk);
        chk({name, " valid_one_cycle"}, int'(sym_valid), 0);
        chk({name, " sym_hold"}, int'(sym_out), sym);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got 0 expected 1");
        $fatal(1);
    end

    initial begin
        int pulses;
        int xv;
        vecs[0] = '{"pos_small", 40000, 2, 7232};
        vecs[1] = '{"neg_big", -100000, 0, -1696};
        vecs[2] = '{"zero_tie", 0, 2, -32768};
        vecs[3] = '{"pos_r_tie", 65536, 3, -32768};
        vecs[4] = '{"neg_r_tie", -65536, 1, -32768};

        reset     = 1'b1;
        sam_en    = 1'b0;
        phase_sel = 2'd0;
        in_s      = '0;
        @(negedge clk);

        do_reset(2);
        chk("rst sym_valid", int'(sym_valid), 0);
        chk("rst sym_out", int'(sym_out), 0);
        chk("rst err", int'(err), 0);
        chk("rst ref_level", int'(ref_level), 65536);

        foreach (vecs[i]) begin
            do_reset(1);
            slice(vecs[i].name, vecs[i].x, vecs[i].sym, vecs[i].err);
        end

        // Phase selection with sam_en held high: inputs 2000, 6000, 10000 kept.
        do_reset(1);
        phase_sel = 2'd2;
        pulses    = 0;
        for (int i = 0; i < 16; i++) begin
            int  j;
            logic exp_v;
            j     = i - 2;
            exp_v = (j >= 0) && (j <= 11) && (j % 4 == 2);
            chk($sformatf("phase valid c%0d", i), int'(sym_valid), int'(exp_v));
            if (sym_valid) pulses++;
            if (exp_v) begin
                chk($sformatf("phase sym c%0d", i), int'(sym_out), 2);
                chk($sformatf("phase err c%0d", i), int'(err), j * 1000 - 32768);
            end
            if (i < 12) begin
                xv     = i * 1000;
                in_s   = xv[17:0];
                sam_en = 1'b1;
            end else begin
                sam_en = 1'b0;
            end
            @(negedge clk);
        end
        chk("phase pulse count", pulses, 3);

        // Reference tracking over 4-symbol windows.
        do_reset(1);
        for (int k = 0; k < 8; k++) begin
            int exp_ref;
            send(k < 4 ? 40000 : -20000);
            @(negedge clk);
            exp_ref = (k < 3) ? 65536 : ((k < 7) ? 40000 : 20000);
            chk($sformatf("ref valid k%0d", k), int'(sym_valid), 1);
            chk($sformatf("ref sym k%0d", k), int'(sym_out), (k < 4) ? 2 : 1);
            chk($sformatf("ref err k%0d", k), int'(err), (k < 4) ? 7232 : 0);
            chk($sformatf("ref level k%0d", k), int'(ref_level), exp_ref);
        end

        // Full-scale averaging then extreme slices.
        do_reset(1);
        for (int k = 0; k < 4; k++) begin
            send(-131072);
            @(negedge clk);
        end
        chk("ext ref_level", int'(ref_level), 131071);
        slice("ext neg", -131072, 0, 65534);
        slice("ext pos", 131071, 3, -65535);

        // Reset while a sample is in flight.
        do_reset(1);
        for (int k = 0; k < 4; k++) begin
            send(40000);
            @(negedge clk);
        end
        chk("mid ref before", int'(ref_level), 40000);
        send(40000);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid ref_level", int'(ref_level), 65536);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("mid no_valid c%0d", k), int'(sym_valid), 0);
            @(negedge clk);
        end
        tb_cnt = 0;
        slice("mid cnt_restart", 40000, 2, 7232);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
